// File: rtl/mkio_pkg.sv
// Shared types and constants for the MKIO remote-terminal front end.
// Contents: command-word layout, dispatcher state encoding, reserved address/subaddress codes.
// No ports; imported by mkio_rt_dispatch and mkio_tx_mux.
package mkio_pkg;

  // Command word as it appears on the channel, MSB first.
  typedef struct packed {
    logic [4:0] addr;
    logic       tr;
    logic [4:0] sa;
    logic [4:0] ncom;
  } mkio_cw_t;

  // Explicit encoding keeps the state register readable in legacy dumps.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_ACTIVE    = 3'd3,
    ST_DRAIN     = 3'd4
  } dispatch_state_t;

  localparam logic [4:0] MKIO_BCAST_ADDR = 5'd31;
  localparam logic [4:0] MKIO_SA_MODE0   = 5'd0;
  localparam logic [4:0] MKIO_SA_MODE31  = 5'd31;

endpackage

// File: rtl/mkio_tx_mux.sv
// Purpose: routes the granted device's tx word/sync/strobe to the shared channel encoder.
// Latency: combinational; zero cycles from grant/dev_tx_* to tx_*.
// Backpressure: none; strobes from ungranted devices are dropped, all-zero output when grant==0.
// Ports: grant_i (one-hot owner), dev_tx_{data,cd,ready}_i (per device), tx_{data,cd,ready}_o.
module mkio_tx_mux
  import mkio_pkg::*;
#(
  parameter int N_DEV = 4
) (
  input  logic [N_DEV-1:0]    grant_i,
  input  logic [16*N_DEV-1:0] dev_tx_data_i,
  input  logic [N_DEV-1:0]    dev_tx_cd_i,
  input  logic [N_DEV-1:0]    dev_tx_ready_i,
  output logic [15:0]         tx_data_o,
  output logic                tx_cd_o,
  output logic                tx_ready_o
);

  // AND-OR mux: grant is one-hot or zero, so at most one term contributes.
  always_comb begin
    tx_data_o  = '0;
    tx_cd_o    = 1'b0;
    tx_ready_o = 1'b0;
    for (int i = 0; i < N_DEV; i++) begin
      if (grant_i[i]) begin
        tx_data_o  = tx_data_o | dev_tx_data_i[16*i +: 16];
        tx_cd_o    = tx_cd_o | dev_tx_cd_i[i];
        tx_ready_o = tx_ready_o | dev_tx_ready_i[i];
      end
    end
  end

endmodule

// File: rtl/mkio_rt_dispatch.sv
// Purpose: MKIO remote-terminal dispatcher; decodes command words, starts the addressed
//          subaddress device and grants it the shared transmitter (never for broadcasts).
// Latency: accepted CW to dev_start is 2 cycles; grant follows dev_busy by 1 cycle.
// Backpressure: none on rx; a new accepted CW preempts the current transaction at once.
// Ports: clk, reset (async, active-high); rx_valid/rx_cd/rx_data from decoder; cmd_word,
//        dev_start to devices; dev_busy, dev_tx_* from devices; tx_* to encoder, tx_busy
//        from encoder; grant; err_unmapped/err_nostart/err_wdog 1-cycle error pulses.
// Build option: define MKIO_WATCHDOG_EN to bound the ACTIVE phase to WDOG_CYC cycles.
module mkio_rt_dispatch
  import mkio_pkg::*;
#(
  parameter logic [4:0]  RT_ADDRESS = 5'd1,
  parameter int          N_DEV      = 4,
  parameter int          BUSY_WAIT  = 4,
  parameter logic [15:0] WDOG_CYC   = 16'd4000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_valid,
  input  logic                rx_cd,
  input  logic [15:0]         rx_data,
  output logic [15:0]         cmd_word,
  output logic [N_DEV-1:0]    dev_start,
  input  logic [N_DEV-1:0]    dev_busy,
  input  logic [16*N_DEV-1:0] dev_tx_data,
  input  logic [N_DEV-1:0]    dev_tx_cd,
  input  logic [N_DEV-1:0]    dev_tx_ready,
  output logic [15:0]         tx_data,
  output logic                tx_cd,
  output logic                tx_ready,
  input  logic                tx_busy,
  output logic [N_DEV-1:0]    grant,
  output logic                err_unmapped,
  output logic                err_nostart,
  output logic                err_wdog
);

  localparam int BW_W = $clog2(BUSY_WAIT + 1);

  dispatch_state_t  state_q, state_d;
  mkio_cw_t         cw_q, cw_d;
  logic             bcast_q, bcast_d;
  logic [N_DEV-1:0] sel_q, sel_d;
  logic [N_DEV-1:0] grant_q, grant_d;
  logic [N_DEV-1:0] start_q, start_d;
  logic [BW_W-1:0]  bw_cnt_q, bw_cnt_d;
  logic             unmapped_q, unmapped_d;
  logic             nostart_q, nostart_d;
`ifdef MKIO_WATCHDOG_EN
  logic [15:0]      wdog_q, wdog_d;
  logic             wdog_err_q, wdog_err_d;
`endif

  mkio_cw_t         rx_cw;
  logic             cw_accept;
  logic             preempt;
  logic             busy_sel;
  logic             sa_mapped;
  logic [N_DEV-1:0] sa_onehot;

  assign rx_cw     = mkio_cw_t'(rx_data);
  assign cw_accept = rx_valid & rx_cd &
                     ((rx_cw.addr == RT_ADDRESS) | (rx_cw.addr == MKIO_BCAST_ADDR));
  // DECODE is deliberately excluded: a CW arriving there is dropped.
  assign preempt   = cw_accept & ((state_q == ST_WAIT_BUSY) | (state_q == ST_ACTIVE) |
                                  (state_q == ST_DRAIN));
  assign busy_sel  = |(dev_busy & sel_q);

  // Subaddress i+1 selects device i; mode codes 0/31 and SAs above N_DEV match nothing.
  always_comb begin
    sa_onehot = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (cw_q.sa == 5'(i + 1)) sa_onehot[i] = 1'b1;
    end
  end
  assign sa_mapped = (cw_q.sa != MKIO_SA_MODE0) & (cw_q.sa != MKIO_SA_MODE31) & (|sa_onehot);

  always_comb begin
    state_d    = state_q;
    cw_d       = cw_q;
    bcast_d    = bcast_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    start_d    = '0;
    bw_cnt_d   = bw_cnt_q;
    unmapped_d = 1'b0;
    nostart_d  = 1'b0;
`ifdef MKIO_WATCHDOG_EN
    wdog_d     = wdog_q;
    wdog_err_d = 1'b0;
`endif
    if ((state_q == ST_IDLE && cw_accept) || preempt) begin
      cw_d    = rx_cw;
      bcast_d = (rx_cw.addr == MKIO_BCAST_ADDR);
      grant_d = '0;
      state_d = ST_DECODE;
    end else begin
      case (state_q)
        ST_DECODE: begin
          if (sa_mapped) begin
            start_d  = sa_onehot;
            sel_d    = sa_onehot;
            bw_cnt_d = '0;
            state_d  = ST_WAIT_BUSY;
          end else begin
            unmapped_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        ST_WAIT_BUSY: begin
          if (busy_sel) begin
            grant_d = bcast_q ? '0 : sel_q;
`ifdef MKIO_WATCHDOG_EN
            wdog_d  = 16'd0;
`endif
            state_d = ST_ACTIVE;
          end else if (bw_cnt_q == BW_W'(BUSY_WAIT - 1)) begin
            nostart_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            bw_cnt_d = bw_cnt_q + 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!busy_sel) begin
            state_d = ST_DRAIN;
          end
`ifdef MKIO_WATCHDOG_EN
          else if (wdog_q == WDOG_CYC - 16'd1) begin
            wdog_err_d = 1'b1;
            grant_d    = '0;
            state_d    = ST_IDLE;
          end else begin
            wdog_d = wdog_q + 16'd1;
          end
`endif
        end
        ST_DRAIN: begin
          // Hold ownership until the encoder has shifted out the last word.
          if (!tx_busy) begin
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cw_q       <= '0;
      bcast_q    <= 1'b0;
      sel_q      <= '0;
      grant_q    <= '0;
      start_q    <= '0;
      bw_cnt_q   <= '0;
      unmapped_q <= 1'b0;
      nostart_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cw_q       <= cw_d;
      bcast_q    <= bcast_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      start_q    <= start_d;
      bw_cnt_q   <= bw_cnt_d;
      unmapped_q <= unmapped_d;
      nostart_q  <= nostart_d;
    end
  end

`ifdef MKIO_WATCHDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q     <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_q     <= wdog_d;
      wdog_err_q <= wdog_err_d;
    end
  end
  assign err_wdog = wdog_err_q;
`else
  assign err_wdog = 1'b0;
`endif

  // A preempting CW must cut the old owner off the encoder in its own cycle,
  // before grant_q is cleared on the next edge.
  assign grant        = grant_q & ~{N_DEV{preempt}};
  assign cmd_word     = cw_q;
  assign dev_start    = start_q;
  assign err_unmapped = unmapped_q;
  assign err_nostart  = nostart_q;

  mkio_tx_mux #(
    .N_DEV (N_DEV)
  ) u_tx_mux (
    .grant_i        (grant),
    .dev_tx_data_i  (dev_tx_data),
    .dev_tx_cd_i    (dev_tx_cd),
    .dev_tx_ready_i (dev_tx_ready),
    .tx_data_o      (tx_data),
    .tx_cd_o        (tx_cd),
    .tx_ready_o     (tx_ready)
  );

endmodule

// File: tb/tb_mkio_rt_dispatch.sv
// Directed bench for mkio_rt_dispatch: reset, normal dispatch, broadcast, unmapped SAs,
// start timeout, preemption, reset mid-transaction and the ACTIVE watchdog.
// Inputs change 1 time unit after the rising edge; outputs are sampled in the same window.
module tb_mkio_rt_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic        rx_cd;
  logic [15:0] rx_data;
  logic [15:0] cmd_word;
  logic [3:0]  dev_start;
  logic [3:0]  dev_busy;
  logic [63:0] dev_tx_data;
  logic [3:0]  dev_tx_cd;
  logic [3:0]  dev_tx_ready;
  logic [15:0] tx_data;
  logic        tx_cd;
  logic        tx_ready;
  logic        tx_busy;
  logic [3:0]  grant;
  logic        err_unmapped;
  logic        err_nostart;
  logic        err_wdog;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mkio_rt_dispatch #(
    .RT_ADDRESS (5'd1),
    .N_DEV      (4),
    .BUSY_WAIT  (4),
    .WDOG_CYC   (16'd50)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_cd        (rx_cd),
    .rx_data      (rx_data),
    .cmd_word     (cmd_word),
    .dev_start    (dev_start),
    .dev_busy     (dev_busy),
    .dev_tx_data  (dev_tx_data),
    .dev_tx_cd    (dev_tx_cd),
    .dev_tx_ready (dev_tx_ready),
    .tx_data      (tx_data),
    .tx_cd        (tx_cd),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .grant        (grant),
    .err_unmapped (err_unmapped),
    .err_nostart  (err_nostart),
    .err_wdog     (err_wdog)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one command-sync word for one cycle; returns with the DUT in DECODE.
  task automatic send_cw(input logic [15:0] w);
    rx_valid = 1'b1;
    rx_cd    = 1'b1;
    rx_data  = w;
    tick();
    rx_valid = 1'b0;
    rx_data  = 16'h0000;
  endtask

  task automatic idle_inputs;
    rx_valid     = 1'b0;
    rx_cd        = 1'b0;
    rx_data      = 16'h0000;
    dev_busy     = 4'b0000;
    dev_tx_ready = 4'b0000;
    tx_busy      = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    dev_tx_data = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    dev_tx_cd   = 4'b1010;
    tick();
    tick();
    checks++; if (cmd_word !== 16'h0000) begin errors++; $display("FAIL reset_cmd_word got %h exp 0000", cmd_word); end
    checks++; if (dev_start !== 4'b0000) begin errors++; $display("FAIL reset_dev_start got %b exp 0000", dev_start); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", grant); end
    checks++; if ({tx_data, tx_cd, tx_ready} !== 18'h0) begin errors++; $display("FAIL reset_tx got %h/%b/%b exp 0", tx_data, tx_cd, tx_ready); end
    checks++; if ({err_unmapped, err_nostart, err_wdog} !== 3'b000) begin errors++; $display("FAIL reset_errs got %b exp 000", {err_unmapped, err_nostart, err_wdog}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_normal;
    int pulses;
    send_cw(16'h0843);
    checks++; if (cmd_word !== 16'h0843) begin errors++; $display("FAIL norm_cmd_word got %h exp 0843", cmd_word); end
    checks++; if (dev_start !== 4'b0000) begin errors++; $display("FAIL norm_start_early got %b exp 0000", dev_start); end
    tick();
    checks++; if (dev_start !== 4'b0010) begin errors++; $display("FAIL norm_dev_start got %b exp 0010", dev_start); end
    tick();
    checks++; if (dev_start !== 4'b0000) begin errors++; $display("FAIL norm_start_pulse got %b exp 0000", dev_start); end
    dev_busy = 4'b0010;
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL norm_grant got %b exp 0010", grant); end
    // Device 0 also strobes; only device 1 must reach the encoder.
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      dev_tx_ready = 4'b0011;
      #1;
      if (tx_ready === 1'b1) pulses++;
      checks++; if ({tx_data, tx_cd} !== {16'hD001, 1'b1}) begin errors++; $display("FAIL norm_tx_word got %h/%b exp D001/1", tx_data, tx_cd); end
      tick();
      dev_tx_ready = 4'b0000;
      tick();
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL norm_tx_pulses got %0d exp 3", pulses); end
    tx_busy  = 1'b1;
    dev_busy = 4'b0000;
    tick();
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL norm_drain_grant got %b exp 0010", grant); end
    tx_busy = 1'b0;
    tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL norm_release got %b exp 0000", grant); end
    tick();
  endtask

  task automatic test_broadcast;
    int leaks;
    send_cw(16'hF843);
    tick();
    checks++; if (dev_start !== 4'b0010) begin errors++; $display("FAIL bcast_dev_start got %b exp 0010", dev_start); end
    dev_busy = 4'b0010;
    leaks = 0;
    for (int k = 0; k < 6; k++) begin
      dev_tx_ready = 4'b0010;
      #1;
      if (tx_ready !== 1'b0 || grant !== 4'b0000) leaks++;
      tick();
    end
    checks++; if (leaks != 0) begin errors++; $display("FAIL bcast_masked got %0d leaking cycles exp 0", leaks); end
    dev_tx_ready = 4'b0000;
    dev_busy     = 4'b0000;
    tick();
    tick();
    tick();
  endtask

  task automatic test_unmapped;
    logic [15:0] cws [3] = '{16'h0800, 16'h0BE0, 16'h08A0};
    for (int k = 0; k < 3; k++) begin
      send_cw(cws[k]);
      tick();
      checks++; if ({err_unmapped, dev_start} !== 5'b1_0000) begin errors++; $display("FAIL unmapped_%h got err=%b start=%b exp err=1 start=0000", cws[k], err_unmapped, dev_start); end
      tick();
      checks++; if ({err_unmapped, dev_start} !== 5'b0_0000) begin errors++; $display("FAIL unmapped_after_%h got err=%b start=%b exp 0/0000", cws[k], err_unmapped, dev_start); end
    end
    send_cw(16'h1043);
    tick();
    checks++; if ({err_unmapped, dev_start} !== 5'b0_0000) begin errors++; $display("FAIL other_addr got err=%b start=%b exp 0/0000", err_unmapped, dev_start); end
    checks++; if (cmd_word !== 16'h08A0) begin errors++; $display("FAIL other_addr_cmd got %h exp 08A0", cmd_word); end
    tick();
  endtask

  task automatic test_nostart;
    int n;
    bit seen;
    send_cw(16'h0823);
    tick();
    checks++; if (dev_start !== 4'b0001) begin errors++; $display("FAIL nostart_dev_start got %b exp 0001", dev_start); end
    n = 0;
    seen = 1'b0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      tick();
      if (err_nostart === 1'b1) begin seen = 1'b1; n = k; end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL nostart_delay got %0d cycles exp 4", n); end
    tick();
    checks++; if ({err_nostart, grant} !== 5'b0_0000) begin errors++; $display("FAIL nostart_after got err=%b grant=%b exp 0/0000", err_nostart, grant); end
  endtask

  task automatic test_preempt;
    send_cw(16'h0823);
    tick();
    dev_busy = 4'b0001;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL pre_grant0 got %b exp 0001", grant); end
    dev_tx_ready = 4'b0001;
    #1;
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL pre_tx_dev0 got %b exp 1", tx_ready); end
    rx_valid = 1'b1;
    rx_cd    = 1'b1;
    rx_data  = 16'h0863;
    #1;
    checks++; if ({grant, tx_ready} !== 5'b0000_0) begin errors++; $display("FAIL pre_same_cycle got grant=%b rdy=%b exp 0000/0", grant, tx_ready); end
    tick();
    rx_valid = 1'b0;
    rx_data  = 16'h0000;
    checks++; if ({grant, tx_ready, cmd_word} !== {4'b0000, 1'b0, 16'h0863}) begin errors++; $display("FAIL pre_decode got grant=%b rdy=%b cw=%h exp 0000/0/0863", grant, tx_ready, cmd_word); end
    tick();
    checks++; if (dev_start !== 4'b0100) begin errors++; $display("FAIL pre_dev_start got %b exp 0100", dev_start); end
    dev_busy = 4'b0101;
    tick();
    checks++; if ({grant, tx_ready} !== 5'b0100_0) begin errors++; $display("FAIL pre_grant2 got grant=%b rdy=%b exp 0100/0", grant, tx_ready); end
    dev_tx_ready = 4'b0101;
    #1;
    checks++; if ({tx_ready, tx_data, tx_cd} !== {1'b1, 16'hD002, 1'b0}) begin errors++; $display("FAIL pre_tx_dev2 got %b/%h/%b exp 1/D002/0", tx_ready, tx_data, tx_cd); end
    reset = 1'b1;
    #1;
    checks++; if ({grant, dev_start, cmd_word, tx_ready, tx_data} !== 41'h0) begin errors++; $display("FAIL mid_reset got grant=%b start=%b cw=%h rdy=%b data=%h exp all 0", grant, dev_start, cmd_word, tx_ready, tx_data); end
    idle_inputs();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_watchdog;
    send_cw(16'h0823);
    tick();
    dev_busy = 4'b0001;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wdog_grant got %b exp 0001", grant); end
`ifdef MKIO_WATCHDOG_EN
    begin
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      for (int k = 1; k <= 100 && !seen; k++) begin
        tick();
        if (err_wdog === 1'b1) begin seen = 1'b1; n = k; end
      end
      checks++; if (n != 50) begin errors++; $display("FAIL wdog_delay got %0d cycles exp 50", n); end
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL wdog_grant_clr got %b exp 0000", grant); end
    end
`else
    begin
      int drops;
      drops = 0;
      for (int k = 0; k < 200; k++) begin
        tick();
        if (grant !== 4'b0001 || err_wdog !== 1'b0) drops++;
      end
      checks++; if (drops != 0) begin errors++; $display("FAIL wdog_hold got %0d bad cycles exp 0", drops); end
    end
`endif
    dev_busy = 4'b0000;
    tick();
    tick();
    tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL wdog_end got %b exp 0000", grant); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_broadcast();
    test_unmapped();
    test_nostart();
    test_preempt();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
